// File: rtl/serv_rf_client_if.sv
// ============================================================================
//  Module   : serv_rf_client_if
//  Purpose  : Bundles the request/response port and the bit-serial register
//             file port of serv_rf_client. The master modport is the client
//             itself; the slave modport is its surroundings (requester plus
//             register file).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serv_rf_client_if;
  // Parallel request side
  logic        i_req_valid;
  logic        o_req_ready;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [4:0]  i_rd_addr;
  logic        i_wen;
  logic [31:0] i_wdata;
  // Parallel response side
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic        o_rsp_err;
  // Bit-serial register file side
  logic        o_rf_go;
  logic        i_rf_ready;
  logic [4:0]  o_rf_rs1_addr;
  logic [4:0]  o_rf_rs2_addr;
  logic [4:0]  o_rf_rd_addr;
  logic        o_rf_rd_en;
  logic        o_rf_rd;
  logic        i_rf_rs1;
  logic        i_rf_rs2;

  modport master (
    input  i_req_valid, i_rs1_addr, i_rs2_addr, i_rd_addr, i_wen, i_wdata,
    input  i_rsp_ready, i_rf_ready, i_rf_rs1, i_rf_rs2,
    output o_req_ready, o_rsp_valid, o_rs1_data, o_rs2_data, o_rsp_err,
    output o_rf_go, o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr, o_rf_rd_en, o_rf_rd
  );

  modport slave (
    output i_req_valid, i_rs1_addr, i_rs2_addr, i_rd_addr, i_wen, i_wdata,
    output i_rsp_ready, i_rf_ready, i_rf_rs1, i_rf_rs2,
    input  o_req_ready, o_rsp_valid, o_rs1_data, o_rs2_data, o_rsp_err,
    input  o_rf_go, o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr, o_rf_rd_en, o_rf_rd
  );
endinterface

`default_nettype wire

// File: rtl/serv_rf_client.sv
// ============================================================================
//  Module   : serv_rf_client
//  Purpose  : Bit-serial initiator for the 2-bit SERV register file. Takes one
//             parallel request, pulses go, waits for ready, deserialises both
//             source operands LSB first and optionally serialises the write
//             data onto the rd stream, then presents a held response.
//  Options  : SERV_RF_CLIENT_TIMEOUT_EN - abort WAIT after TIMEOUT cycles and
//             report o_rsp_err.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serv_rf_client #(
  parameter int TIMEOUT = 4
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  serv_rf_client_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GO    = 3'd1,
    WAIT  = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    RESP  = 3'd5
  } state_t;

  // Last WAIT count before giving up (count starts at 0 on WAIT entry)
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

  state_t      state;
  logic [4:0]  bit_cnt;
  logic        skip_write;
  logic        rs1_nz;
  logic        rs2_nz;
  logic [31:0] wdata_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [4:0]  rs1_addr_q;
  logic [4:0]  rs2_addr_q;
  logic [4:0]  rd_addr_q;
  logic        go_q;
  logic        rd_en_q;
  logic        rsp_valid_q;
  logic        accept;
`ifdef SERV_RF_CLIENT_TIMEOUT_EN
  logic [3:0]  wait_cnt;
  logic        rsp_err_q;
`else
  logic        unused_timeout_last;
`endif

  // Ready is withheld for as long as reset is asserted
  assign bus.o_req_ready = (state == IDLE) && !i_rst;
  assign accept          = bus.i_req_valid && bus.o_req_ready;

  // Request sequencing: handshake, serial read, optional serial write, response
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      bit_cnt     <= 5'd0;
      skip_write  <= 1'b0;
      rs1_nz      <= 1'b0;
      rs2_nz      <= 1'b0;
      wdata_q     <= 32'd0;
      rs1_q       <= 32'd0;
      rs2_q       <= 32'd0;
      rs1_addr_q  <= 5'd0;
      rs2_addr_q  <= 5'd0;
      rd_addr_q   <= 5'd0;
      go_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef SERV_RF_CLIENT_TIMEOUT_EN
      wait_cnt    <= 4'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      go_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rs1_addr_q <= bus.i_rs1_addr;
            rs2_addr_q <= bus.i_rs2_addr;
            rd_addr_q  <= bus.i_rd_addr;
            wdata_q    <= bus.i_wdata;
            // x0 is architecturally zero: never write it, never trust its word
            skip_write <= !bus.i_wen || (bus.i_rd_addr == 5'd0);
            rs1_nz     <= (bus.i_rs1_addr != 5'd0);
            rs2_nz     <= (bus.i_rs2_addr != 5'd0);
            rs1_q      <= 32'd0;
            rs2_q      <= 32'd0;
            go_q       <= 1'b1;
            state      <= GO;
          end
        end
        GO: begin
`ifdef SERV_RF_CLIENT_TIMEOUT_EN
          wait_cnt <= 4'd0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (bus.i_rf_ready) begin
            bit_cnt <= 5'd0;
            state   <= READ;
          end
`ifdef SERV_RF_CLIENT_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end
        READ: begin
          rs1_q[bit_cnt] <= bus.i_rf_rs1 & rs1_nz;
          rs2_q[bit_cnt] <= bus.i_rf_rs2 & rs2_nz;
          bit_cnt        <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            if (skip_write) begin
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              rd_en_q <= 1'b1;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          // Exactly 32 rd_en cycles keep the regfile's even/odd pairing aligned
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
`ifdef SERV_RF_CLIENT_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_rf_go       = go_q;
  assign bus.o_rf_rs1_addr = rs1_addr_q;
  assign bus.o_rf_rs2_addr = rs2_addr_q;
  assign bus.o_rf_rd_addr  = rd_addr_q;
  assign bus.o_rf_rd_en    = rd_en_q;
  assign bus.o_rf_rd       = rd_en_q & wdata_q[bit_cnt];
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rs1_data    = rs1_q;
  assign bus.o_rs2_data    = rs2_q;

`ifdef SERV_RF_CLIENT_TIMEOUT_EN
  assign bus.o_rsp_err = rsp_err_q;
`else
  assign bus.o_rsp_err       = 1'b0;
  assign unused_timeout_last = ^TIMEOUT_LAST;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serv_rf_client.sv
// ============================================================================
//  Module   : tb_serv_rf_client
//  Purpose  : Self-checking bench for serv_rf_client with a behavioural
//             bit-serial register file and an architectural register model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serv_rf_client;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serv_rf_client_if bus ();

  serv_rf_client #(.TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  // Physical regfile contents (word 0 holds junk) and architectural view
  logic [31:0] mem     [32];
  logic [31:0] exp_reg [32];
  bit          mute  = 1'b0;
  bit          noise = 1'b0;
  int          phase = 0;
  logic [4:0]  wcnt  = 5'd0;

  // Behavioural register file: ready two cycles after go, then 32 read bits;
  // write bits land at a free-running, reset-only bit position
  initial begin
    bus.i_rf_ready = 1'b0;
    bus.i_rf_rs1   = 1'b0;
    bus.i_rf_rs2   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        phase = 0;
        wcnt  = 5'd0;
        bus.i_rf_ready = 1'b0;
        bus.i_rf_rs1   = 1'b0;
        bus.i_rf_rs2   = 1'b0;
      end else begin
        if (bus.o_rf_rd_en) begin
          mem[bus.o_rf_rd_addr][wcnt] = bus.o_rf_rd;
          wcnt = wcnt + 5'd1;
        end
        if (phase == 0) begin
          if (bus.o_rf_go && !mute) phase = 1;
        end else begin
          phase = phase + 1;
        end
        bus.i_rf_ready = (phase == 3) ||
                         ((phase == 0 || phase >= 4) && noise && !mute &&
                          ($urandom_range(0, 3) == 0));
        if (phase >= 4 && phase <= 35) begin
          bus.i_rf_rs1 = mem[bus.o_rf_rs1_addr][phase-4];
          bus.i_rf_rs2 = mem[bus.o_rf_rs2_addr][phase-4];
        end else begin
          bus.i_rf_rs1 = $urandom_range(0, 1) == 1;
          bus.i_rf_rs2 = $urandom_range(0, 1) == 1;
        end
        if (phase == 35) phase = 0;
      end
    end
  end

  // Present a request in the current cycle; it is accepted at the next edge
  task automatic present(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                         input logic wen, input logic [31:0] wd);
    bus.i_rs1_addr  = a1;
    bus.i_rs2_addr  = a2;
    bus.i_rd_addr   = ad;
    bus.i_wen       = wen;
    bus.i_wdata     = wd;
    bus.i_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
  endtask

  // One full transaction checked against the architectural model
  task automatic run_txn(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                         input logic wen, input logic [31:0] wd, input int hold,
                         input string tag);
    logic [31:0] e1, e2, s1, s2;
    int lat, rden, extra_go, exp_lat, exp_rden;
    bit stable;
    e1 = (a1 == 5'd0) ? 32'd0 : exp_reg[a1];
    e2 = (a2 == 5'd0) ? 32'd0 : exp_reg[a2];
    exp_lat  = (wen && ad != 5'd0) ? 68 : 36;
    exp_rden = (wen && ad != 5'd0) ? 32 : 0;

    checks++;
    if (bus.o_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s req_ready_at_accept got=%b want=1", tag, bus.o_req_ready);
    end
    present(a1, a2, ad, wen, wd);
    checks++;
    if (bus.o_rf_go !== 1'b1) begin
      fails++;
      $display("FAIL %s go_in_c1 got=%b want=1", tag, bus.o_rf_go);
    end
    lat = 1; rden = 0; extra_go = 0;
    while (bus.o_rsp_valid !== 1'b1 && lat < 200) begin
      if (bus.o_rf_rd_en === 1'b1) rden++;
      @(posedge clk); #1;
      lat++;
      if (bus.o_rf_go === 1'b1) extra_go++;
    end
    checks++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s rsp_latency got=%0d want=%0d", tag, lat, exp_lat);
    end
    checks++;
    if (rden !== exp_rden || extra_go !== 0) begin
      fails++;
      $display("FAIL %s rd_en_cycles/extra_go got=%0d/%0d want=%0d/0", tag, rden, extra_go, exp_rden);
    end
    checks++;
    if (bus.o_rs1_data !== e1 || bus.o_rs2_data !== e2 || bus.o_rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL %s rsp_data got=%h/%h err=%b want=%h/%h err=0",
               tag, bus.o_rs1_data, bus.o_rs2_data, bus.o_rsp_err, e1, e2);
    end
    s1 = bus.o_rs1_data; s2 = bus.o_rs2_data; stable = 1'b1;
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.o_rsp_valid !== 1'b1 || bus.o_req_ready !== 1'b0 ||
          bus.o_rs1_data !== s1 || bus.o_rs2_data !== s2) stable = 1'b0;
    end
    if (hold > 0) begin
      checks++;
      if (!stable) begin
        fails++;
        $display("FAIL %s rsp_hold_stable got=0 want=1", tag);
      end
    end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b0;
    checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s after_handshake valid/ready got=%b/%b want=0/1",
               tag, bus.o_rsp_valid, bus.o_req_ready);
    end
    if (wen && ad != 5'd0) exp_reg[ad] = wd;
  endtask

  function automatic logic [84:0] all_outputs();
    return {bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_err, bus.o_rf_go, bus.o_rf_rd_en,
            bus.o_rf_rd, bus.o_rf_rs1_addr, bus.o_rf_rs2_addr, bus.o_rf_rd_addr,
            bus.o_rs1_data, bus.o_rs2_data};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h want=0", all_outputs());
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.o_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got=%b want=1", bus.o_req_ready);
    end
  endtask

  task automatic test_directed();
    run_txn(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF, 0, "write_x5");
    run_txn(5'd5, 5'd5, 5'd0, 1'b0, 32'h0, 0, "read_x5");
    run_txn(5'd0, 5'd0, 5'd7, 1'b1, 32'h00000001, 0, "write_x7");
    run_txn(5'd0, 5'd7, 5'd0, 1'b0, 32'h0, 0, "read_x0_x7");
  endtask

  task automatic test_x0_write();
    run_txn(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 0, "write_x0");
    for (int r = 1; r < 32; r += 2)
      run_txn(5'(r), 5'((r + 1) % 32), 5'd0, 1'b0, 32'h0, 0, "scan_after_x0");
  endtask

  task automatic test_back_to_back();
    run_txn(5'd5, 5'd7, 5'd9, 1'b1, 32'hA5A55A5A, 10, "backpressure");
    run_txn(5'd9, 5'd5, 5'd0, 1'b0, 32'h0, 0, "back_to_back");
  endtask

  task automatic test_random();
    noise = 1'b1;
    for (int n = 0; n < 40; n++)
      run_txn(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              $urandom, $urandom_range(0, 3), "random");
    noise = 1'b0;
  endtask

  task automatic test_reset_mid();
    present(5'd1, 5'd2, 5'd3, 1'b1, 32'hCAFEF00D);
    repeat (49) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs got=%h want=0", all_outputs());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(5'd0, 5'd0, 5'd3, 1'b1, 32'h12345678, 0, "write_x3_after_reset");
    run_txn(5'd3, 5'd3, 5'd0, 1'b0, 32'h0, 0, "read_x3_after_reset");
  endtask

  task automatic test_timeout();
    int lat;
    mute = 1'b1;
    present(5'd5, 5'd7, 5'd4, 1'b1, 32'h11111111);
    lat = 1;
    while (bus.o_rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
`ifdef SERV_RF_CLIENT_TIMEOUT_EN
    checks++;
    if (lat !== 6 || bus.o_rsp_err !== 1'b1 || bus.o_rs1_data !== 32'd0 ||
        bus.o_rs2_data !== 32'd0 || bus.o_rf_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL timeout_rsp lat=%0d err=%b data=%h/%h want lat=6 err=1 data=0/0",
               lat, bus.o_rsp_err, bus.o_rs1_data, bus.o_rs2_data);
    end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b0;
    checks++;
    if (bus.o_rsp_err !== 1'b0 || bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_clear err/valid/ready got=%b/%b/%b want=0/0/1",
               bus.o_rsp_err, bus.o_rsp_valid, bus.o_req_ready);
    end
`else
    checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL wait_blocks valid/err got=%b/%b want=0/0 after %0d cycles",
               bus.o_rsp_valid, bus.o_rsp_err, lat);
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
`endif
    mute = 1'b0;
    run_txn(5'd5, 5'd7, 5'd0, 1'b0, 32'h0, 0, "after_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_rs1_addr  = 5'd0;
    bus.i_rs2_addr  = 5'd0;
    bus.i_rd_addr   = 5'd0;
    bus.i_wen       = 1'b0;
    bus.i_wdata     = 32'd0;
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = $urandom;
      exp_reg[i] = (i == 0) ? 32'd0 : mem[i];
    end
    test_reset();
    test_directed();
    test_x0_write();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serv_rf_client.md
# serv_rf_client

Bit-serial initiator for the SERV 2-bit-wide register file: accepts one parallel request (two source reads, optional destination write), runs the regfile go/ready handshake, deserialises both 32-bit operands and serialises the write data onto the rd stream. It sits between a parallel-datapath master (debug module, test harness, non-serial core) and the serial register file, sharing that file's clock and reset.

## Interface
- TIMEOUT, 4: cycles to wait for i_rf_ready after o_rf_go before aborting. Used only when SERV_RF_CLIENT_TIMEOUT_EN is defined; legal range 2..15.

- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high; the same net also resets the register file
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid & ready
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  5 each  source/destination register numbers
- i_wen  in  1  perform the write
- i_wdata  in  32  write data
- o_rsp_valid  out  1  response valid, held until i_rsp_ready
- i_rsp_ready  in  1  response consumed
- o_rs1_data, o_rs2_data  out  32 each  operand values
- o_rsp_err  out  1  ready timeout; constant 0 without the macro
- o_rf_go  out  1  one-cycle start pulse to the regfile
- i_rf_ready  in  1  regfile ready pulse
- o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr  out  5 each  registered addresses
- o_rf_rd_en  out  1  write-stream enable
- o_rf_rd  out  1  write-stream bit
- i_rf_rs1, i_rf_rs2  in  1 each  read-stream bits

## Operation
- States: IDLE, GO, WAIT, READ, WRITE, RESP.
- IDLE: o_req_ready=1. On accept, register all request fields. Set the skip-write flag when i_wen=0 or i_rd_addr=0. Go to GO.
- GO: o_rf_go=1 for exactly one cycle, then WAIT.
- WAIT: when i_rf_ready=1 is sampled, go to READ with bit counter=0.
- READ: 32 cycles. At each edge, shift i_rf_rs1/i_rf_rs2 into bit[counter], LSB first. After bit 31: go to WRITE, or to RESP if skip-write is set.
- WRITE: 32 cycles with o_rf_rd_en=1; o_rf_rd = wdata[counter], LSB first. Then go to RESP.
- RESP: o_rsp_valid=1. On i_rsp_ready, go to IDLE.
- Addresses on o_rf_* hold their registered values from accept through the end of RESP.
- Zero-register forcing: if rs1_addr=0, o_rs1_data=0 regardless of the stream (memory word 0 is never written or initialised). Same rule for rs2.
- The regfile write counter is reset-only. Every WRITE therefore asserts rd_en for exactly 32 consecutive cycles, which preserves its even/odd pairing. rd_en is never asserted outside WRITE.
- Bit counter is 5 bits and wraps 31→0 on phase exit.

## Timing
- Reset values: o_req_ready=1 once out of reset (0 while i_rst is high); every other output is 0, including o_rsp_data and the addresses.
- With accept in cycle c0:
  - o_rf_go is high in c1.
  - i_rf_ready is high in c3.
  - READ spans c4..c35; bit 0 of both operands is sampled at the end of c4.
  - Without a write, o_rsp_valid rises in c36 (latency 36).
  - With a write, WRITE spans c36..c67 and o_rsp_valid rises in c68.
- Back-to-back: the next accept can occur in the cycle after the response handshake.
- i_rf_ready outside WAIT is ignored.
- Reset mid-operation: immediate return to IDLE, outputs go to reset values, and any partial write is abandoned. The regfile counter is cleared by the same reset.

## Configuration
- SERV_RF_CLIENT_TIMEOUT_EN defined:
  - WAIT counts cycles. If i_rf_ready has not been seen after TIMEOUT cycles, go to RESP with o_rsp_err=1 and both data outputs 0; no READ or WRITE.
  - o_rsp_err clears on the response handshake.
- Undefined: WAIT blocks indefinitely and o_rsp_err is tied 0.

## Test plan
- Write x5=0xDEADBEEF (rs1=rs2=0, wen=1), then read rs1=5, rs2=5 with wen=0 → o_rs1_data=o_rs2_data=0xDEADBEEF. Write response at c68, read response at c36.
- Read rs1=0, rs2=7 after writing x7=0x00000001 → o_rs1_data=0, o_rs2_data=1.
- Write with rd_addr=0, wen=1, wdata=0xFFFFFFFF → no rd_en cycle; response at c36; subsequent reads of x1..x31 are unchanged.
- Hold i_rsp_ready=0 for 10 cycles in RESP → o_rsp_valid and data stable, o_req_ready=0; accept again one cycle after the handshake.
- Assert i_rst in cycle 50 of a write to x3 → all outputs 0 immediately. A fresh write x3=0x12345678 followed by a read returns 0x12345678, which proves the rd_en pairing is intact.
- With the macro and TIMEOUT=4, tie i_rf_ready=0 → o_rsp_valid with o_rsp_err=1 and data 0, after 4 cycles in WAIT. Without the macro, o_rsp_valid stays 0 for 100 cycles.
